// File: rtl/matmul_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module   : matmul_sequencer_if
// Purpose  : Bundles the control/status and operand/result memory signals of
//            the matrix-multiply sequencer.
// Ports    : (interface signals)
//            start, abort, irq_clr     - control from the register bank
//            busy, done, irq           - status back to the register bank
//            rd_en, a_addr, b_addr     - operand read request to A/B memories
//            a_data, b_data            - operand read data (1 cycle after rd_en)
//            c_we, c_addr, c_data      - result write to C memory
// Modports : master - sequencer side (drives status, addresses, results)
//            slave  - environment side (register bank + memories)
// Revision : 1.0 - initial release
// ============================================================================
interface matmul_sequencer_if #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(N),
    parameter int ADDR_W = $clog2(N*N)
);
    logic              start;
    logic              abort;
    logic              irq_clr;
    logic              busy;
    logic              done;
    logic              irq;
    logic              rd_en;
    logic [ADDR_W-1:0] a_addr;
    logic [ADDR_W-1:0] b_addr;
    logic [DATA_W-1:0] a_data;
    logic [DATA_W-1:0] b_data;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [ACC_W-1:0]  c_data;

    modport master (
        input  start, abort, irq_clr, a_data, b_data,
        output busy, done, irq, rd_en, a_addr, b_addr, c_we, c_addr, c_data
    );

    modport slave (
        output start, abort, irq_clr, a_data, b_data,
        input  busy, done, irq, rd_en, a_addr, b_addr, c_we, c_addr, c_data
    );
endinterface
`default_nettype wire

// File: rtl/matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : matmul_sequencer
// Purpose  : Walks the i/j/k loops of C = A x B over NxN row-major operand
//            memories, multiply-accumulates each dot product and writes C.
// Ports    : ACLK    - clock
//            ARESET  - asynchronous reset, active-high
//            bus     - matmul_sequencer_if.master (control, status, memories)
// Options  : MATMUL_IRQ_EN - when defined, irq is a sticky completion flag
//                            cleared by irq_clr; otherwise irq is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module matmul_sequencer #(
    parameter int N      = 2,
    parameter int DATA_W = 8,
    parameter int ACC_W  = 2*DATA_W + $clog2(N),
    parameter int ADDR_W = $clog2(N*N)
) (
    input  logic               ACLK,
    input  logic               ARESET,
    matmul_sequencer_if.master bus
);
    localparam int c_idx_w = $clog2(N);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_fetch = 3'd1;
    localparam logic [2:0] c_st_drain = 3'd2;
    localparam logic [2:0] c_st_write = 3'd3;
    localparam logic [2:0] c_st_done  = 3'd4;

    localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(N-1);
    localparam logic [c_idx_w-1:0] c_idx_one  = c_idx_w'(1);
    localparam logic [ADDR_W-1:0]  c_n_addr   = ADDR_W'(N);

    logic [2:0]         r_state;
    logic [c_idx_w-1:0] r_i;
    logic [c_idx_w-1:0] r_j;
    logic [c_idx_w-1:0] r_k;
    logic [ACC_W-1:0]   r_acc;
    logic               r_busy;
    logic               r_done;
    logic               r_rd_en;
    logic [ADDR_W-1:0]  r_a_addr;
    logic [ADDR_W-1:0]  r_b_addr;
    logic               r_c_we;
    logic [ADDR_W-1:0]  r_c_addr;
    logic [ACC_W-1:0]   r_c_data;

    logic [2*DATA_W-1:0] w_prod;
    logic [ACC_W-1:0]    w_prod_ext;
    logic [ACC_W-1:0]    w_acc_sum;
    logic                w_k_last;
    logic                w_j_last;
    logic                w_i_last;
    logic [c_idx_w-1:0]  w_k_inc;
    logic [c_idx_w-1:0]  w_j_nxt;
    logic [c_idx_w-1:0]  w_i_nxt;
    logic                w_in_op;
    logic                w_abort;

    // Row-major element address: row*N + col.
    function automatic logic [ADDR_W-1:0] f_addr(
        input logic [c_idx_w-1:0] row,
        input logic [c_idx_w-1:0] col
    );
        logic [ADDR_W-1:0] row_ext;
        logic [ADDR_W-1:0] col_ext;
        row_ext = {{(ADDR_W-c_idx_w){1'b0}}, row};
        col_ext = {{(ADDR_W-c_idx_w){1'b0}}, col};
        return row_ext * c_n_addr + col_ext;
    endfunction

    // Full-width unsigned product, zero-extended into the accumulator width.
    assign w_prod     = {{DATA_W{1'b0}}, bus.a_data} * {{DATA_W{1'b0}}, bus.b_data};
    assign w_prod_ext = {{(ACC_W-2*DATA_W){1'b0}}, w_prod};
    assign w_acc_sum  = r_acc + w_prod_ext;

    assign w_k_last = (r_k == c_idx_last);
    assign w_j_last = (r_j == c_idx_last);
    assign w_i_last = (r_i == c_idx_last);
    assign w_k_inc  = r_k + c_idx_one;
    assign w_j_nxt  = w_j_last ? '0 : (r_j + c_idx_one);
    assign w_i_nxt  = w_j_last ? (r_i + c_idx_one) : r_i;

    // Abort only matters while an operation is running; in IDLE it simply
    // masks start, and DONE always completes.
    assign w_in_op = (r_state == c_st_fetch) || (r_state == c_st_drain) ||
                     (r_state == c_st_write);
    assign w_abort = bus.abort && w_in_op;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state  <= c_st_idle;
            r_i      <= '0;
            r_j      <= '0;
            r_k      <= '0;
            r_acc    <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_rd_en  <= 1'b0;
            r_a_addr <= '0;
            r_b_addr <= '0;
            r_c_we   <= 1'b0;
            r_c_addr <= '0;
            r_c_data <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                // c_addr/c_data keep the last written result.
                r_state  <= c_st_idle;
                r_i      <= '0;
                r_j      <= '0;
                r_k      <= '0;
                r_acc    <= '0;
                r_busy   <= 1'b0;
                r_rd_en  <= 1'b0;
                r_a_addr <= '0;
                r_b_addr <= '0;
                r_c_we   <= 1'b0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (bus.start && !bus.abort) begin
                            r_state  <= c_st_fetch;
                            r_busy   <= 1'b1;
                            r_rd_en  <= 1'b1;
                            r_i      <= '0;
                            r_j      <= '0;
                            r_k      <= '0;
                            r_acc    <= '0;
                            r_a_addr <= '0;
                            r_b_addr <= '0;
                        end
                    end

                    c_st_fetch: begin
                        // Read data returns one cycle late, so the first
                        // fetch cycle of a dot product has nothing to add.
                        if (r_k != '0) begin
                            r_acc <= w_acc_sum;
                        end
                        if (w_k_last) begin
                            r_state <= c_st_drain;
                            r_rd_en <= 1'b0;
                        end else begin
                            r_k      <= w_k_inc;
                            r_a_addr <= f_addr(r_i, w_k_inc);
                            r_b_addr <= f_addr(w_k_inc, r_j);
                        end
                    end

                    c_st_drain: begin
                        // Fold in the last product and present it for the
                        // write cycle directly from the sum.
                        r_state  <= c_st_write;
                        r_acc    <= w_acc_sum;
                        r_c_we   <= 1'b1;
                        r_c_addr <= f_addr(r_i, r_j);
                        r_c_data <= w_acc_sum;
                    end

                    c_st_write: begin
                        r_c_we <= 1'b0;
                        r_acc  <= '0;
                        r_k    <= '0;
                        if (w_i_last && w_j_last) begin
                            r_state <= c_st_done;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_i     <= '0;
                            r_j     <= '0;
                        end else begin
                            r_state  <= c_st_fetch;
                            r_rd_en  <= 1'b1;
                            r_i      <= w_i_nxt;
                            r_j      <= w_j_nxt;
                            r_a_addr <= f_addr(w_i_nxt, '0);
                            r_b_addr <= f_addr('0, w_j_nxt);
                        end
                    end

                    c_st_done: begin
                        r_state <= c_st_idle;
                    end

                    default: begin
                        r_state <= c_st_idle;
                        r_busy  <= 1'b0;
                        r_rd_en <= 1'b0;
                        r_c_we  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.busy   = r_busy;
    assign bus.done   = r_done;
    assign bus.rd_en  = r_rd_en;
    assign bus.a_addr = r_a_addr;
    assign bus.b_addr = r_b_addr;
    assign bus.c_we   = r_c_we;
    assign bus.c_addr = r_c_addr;
    assign bus.c_data = r_c_data;

`ifdef MATMUL_IRQ_EN
    logic r_irq;

    // Set in the DONE cycle takes priority over a simultaneous clear.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_irq <= 1'b0;
        end else if (r_state == c_st_done) begin
            r_irq <= 1'b1;
        end else if (bus.irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign bus.irq = r_irq;
`else
    logic w_unused_irq_clr;

    assign w_unused_irq_clr = bus.irq_clr;
    assign bus.irq          = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_matmul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_matmul_sequencer
// Purpose  : Self-checking bench for matmul_sequencer (N=2, DATA_W=8).
//            Stimulus pushes expected C writes and done times into queues;
//            a monitor pops and compares whenever c_we or done is seen.
// Revision : 1.0 - initial release
// ============================================================================
module tb_matmul_sequencer;
    localparam int N      = 2;
    localparam int DATA_W = 8;
    localparam int ACC_W  = 17;
    localparam int ADDR_W = 2;
    localparam int LAT    = 17;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    matmul_sequencer_if #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) bus ();

    matmul_sequencer #(.N(N), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W)) dut (
        .ACLK   (clk),
        .ARESET (rst),
        .bus    (bus)
    );

    logic [DATA_W-1:0] a_mem [N*N];
    logic [DATA_W-1:0] b_mem [N*N];

    // Synchronous operand memories: data valid one cycle after rd_en.
    always @(posedge clk) begin
        if (rst) begin
            bus.a_data <= '0;
            bus.b_data <= '0;
        end else if (bus.rd_en) begin
            bus.a_data <= a_mem[bus.a_addr];
            bus.b_data <= b_mem[bus.b_addr];
        end
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned addr;
        int unsigned data;
    } wr_t;

    wr_t exp_wr_q[$];
    int  exp_done_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: compares every presented write and every done pulse.
    always @(negedge clk) begin
        if (bus.c_we === 1'b1) begin
            if (exp_wr_q.size() == 0) begin
                chk("c_we_unexpected", {63'd0, bus.c_we}, 64'd0);
            end else begin
                wr_t e;
                e = exp_wr_q.pop_front();
                chk("c_addr", {62'd0, bus.c_addr}, 64'(e.addr));
                chk("c_data", {47'd0, bus.c_data}, 64'(e.data));
            end
        end
        if (bus.done === 1'b1) begin
            if (exp_done_q.size() == 0) begin
                chk("done_unexpected", {63'd0, bus.done}, 64'd0);
            end else begin
                int t;
                t = exp_done_q.pop_front();
                chk("done_cycle", 64'(cyc), 64'(t));
            end
        end
    end

    task automatic load(input int a0, a1, a2, a3, b0, b1, b2, b3);
        a_mem[0] = 8'(a0); a_mem[1] = 8'(a1); a_mem[2] = 8'(a2); a_mem[3] = 8'(a3);
        b_mem[0] = 8'(b0); b_mem[1] = 8'(b1); b_mem[2] = 8'(b2); b_mem[3] = 8'(b3);
    endtask

    task automatic push_wr(input int unsigned addr, input int unsigned data);
        wr_t e;
        e.addr = addr;
        e.data = data;
        exp_wr_q.push_back(e);
    endtask

    // Returns at the negedge of cycle 1 (first FETCH cycle); t0 is cycle 0.
    task automatic pulse_start(input bit expect_done, output int t0);
        @(negedge clk);
        t0 = cyc;
        if (expect_done) exp_done_q.push_back(t0 + LAT);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic wait_done(input int bound);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < bound && !seen; n++) begin
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
        end
        chk("done_seen", {63'd0, seen}, 64'd1);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},   {63'd0, bus.busy},   64'd0);
        chk({tag, "_done"},   {63'd0, bus.done},   64'd0);
        chk({tag, "_irq"},    {63'd0, bus.irq},    64'd0);
        chk({tag, "_rd_en"},  {63'd0, bus.rd_en},  64'd0);
        chk({tag, "_c_we"},   {63'd0, bus.c_we},   64'd0);
        chk({tag, "_a_addr"}, {62'd0, bus.a_addr}, 64'd0);
        chk({tag, "_b_addr"}, {62'd0, bus.b_addr}, 64'd0);
        chk({tag, "_c_addr"}, {62'd0, bus.c_addr}, 64'd0);
        chk({tag, "_c_data"}, {47'd0, bus.c_data}, 64'd0);
    endtask

    task automatic push_basic();
        push_wr(0, 19); push_wr(1, 22); push_wr(2, 43); push_wr(3, 50);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst         = 1'b1;
        bus.start   = 1'b0;
        bus.abort   = 1'b0;
        bus.irq_clr = 1'b0;
        load(1, 2, 3, 4, 5, 6, 7, 8);
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_all_zero("idle");

        // Basic product with busy window and completion timing.
        push_basic();
        pulse_start(1'b1, t0);
        chk("busy_c1", {63'd0, bus.busy}, 64'd1);
        chk("rd_en_c1", {63'd0, bus.rd_en}, 64'd1);
        wait_cyc(t0 + 16);
        chk("busy_c16", {63'd0, bus.busy}, 64'd1);
        wait_done(30);
        chk("busy_in_done", {63'd0, bus.busy}, 64'd0);
        @(negedge clk);
`ifdef MATMUL_IRQ_EN
        chk("irq_set", {63'd0, bus.irq}, 64'd1);
        repeat (3) @(negedge clk);
        chk("irq_sticky", {63'd0, bus.irq}, 64'd1);
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
        chk("irq_cleared", {63'd0, bus.irq}, 64'd0);
`else
        chk("irq_tied_low", {63'd0, bus.irq}, 64'd0);
`endif

        // Maximum operands: no truncation of 2*255*255.
        load(255, 255, 255, 255, 255, 255, 255, 255);
        repeat (4) push_wr(0, 130050);
        exp_wr_q[1].addr = 1; exp_wr_q[2].addr = 2; exp_wr_q[3].addr = 3;
`ifdef MATMUL_IRQ_EN
        bus.irq_clr = 1'b1;
`endif
        pulse_start(1'b1, t0);
        wait_done(30);
        @(negedge clk);
`ifdef MATMUL_IRQ_EN
        bus.irq_clr = 1'b0;
        chk("irq_set_wins", {63'd0, bus.irq}, 64'd1);
        bus.irq_clr = 1'b1;
        @(negedge clk);
        bus.irq_clr = 1'b0;
`endif

        // Start while busy is ignored.
        load(1, 2, 3, 4, 5, 6, 7, 8);
        push_basic();
        pulse_start(1'b1, t0);
        wait_cyc(t0 + 5);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(30);
        @(negedge clk);

        // Abort during the second element's fetch.
        push_wr(0, 19);
        pulse_start(1'b0, t0);
        wait_cyc(t0 + 6);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        wait_cyc(t0 + 8);
        chk("abort_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_rd_en", {63'd0, bus.rd_en}, 64'd0);
        wait_cyc(t0 + 30);
        chk("abort_irq", {63'd0, bus.irq}, 64'd0);

        // Abort together with start in IDLE: stays idle.
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("abort_start_busy", {63'd0, bus.busy}, 64'd0);
        chk("abort_start_rd_en", {63'd0, bus.rd_en}, 64'd0);
        repeat (5) @(negedge clk);

        push_basic();
        pulse_start(1'b1, t0);
        wait_done(30);
        @(negedge clk);

        // Asynchronous reset mid-operation.
        push_wr(0, 19); push_wr(1, 22);
        pulse_start(1'b0, t0);
        wait_cyc(t0 + 9);
        rst = 1'b1;
        #1;
        chk_all_zero("areset");
        @(negedge clk);
        rst = 1'b0;
        repeat (25) @(negedge clk);
        chk("areset_busy", {63'd0, bus.busy}, 64'd0);

        push_basic();
        pulse_start(1'b1, t0);
        wait_done(30);
        repeat (3) @(negedge clk);

        chk("wr_queue_empty", 64'(exp_wr_q.size()), 64'd0);
        chk("done_queue_empty", 64'(exp_done_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
